rgb_fade_sequencer: RTL and testbench
=====================================

Name: rgb_fade_sequencer

Overview:
Controller that sequences the 8-bit R/G/B duty values driven into the team's RGB PWM generator. It steps through a fixed 8-entry colour palette, either fading linearly or jumping between entries, or holds a switch-selected colour. Duty updates are committed only at PWM period boundaries, so the generator never sees a mid-period duty change.

Parameters:
TICK_DIV, 250000, clk cycles per fade step tick (>=2)
HOLD_TICKS, 100, ticks to dwell on a reached colour in auto modes (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset (asserted when 0)
en  input  1  run enable; 0 freezes prescaler, FSM, hold counter and internal duties
mode  input  2  00 auto fade, 01 auto jump, 10 manual (palette[sel]), 11 off (fade to black)
sel  input  3  palette index used in mode 10
pwm_frame_end  input  1  one-cycle pulse from PWM generator at end of each PWM period
R_time_out  output  8  committed red duty
G_time_out  output  8  committed green duty
B_time_out  output  8  committed blue duty
upd  output  1  one-cycle pulse in the cycle committed duties change
color_idx  output  3  current palette target index
busy  output  1  1 while any internal channel differs from target

Behaviour:
- Palette (R,G,B): 0 (255,0,0), 1 (255,97,0), 2 (255,255,0), 3 (0,255,0), 4 (0,0,255), 5 (8,46,84), 6 (160,32,240), 7 (255,255,255). Auto modes cycle 0..6 and wrap 6->0; index 7 is reachable only via mode 10.
- Reset (rst=0, async): all outputs 0, internal duties cur_r/g/b=0, color_idx=0, prescaler=0, hold counter=0, state IDLE.
- Prescaler: counts 0..TICK_DIV-1 while en=1; tick = 1 for one cycle when count==TICK_DIV-1, then wraps to 0. First tick occurs TICK_DIV cycles after en rises out of reset.
- Target: modes 00/01 -> palette[color_idx]; mode 10 -> palette[sel], color_idx tracks sel; mode 11 -> (0,0,0), color_idx holds. Mode/sel sampled only on tick.
- States: IDLE, FADE, HOLD, DARK.
  IDLE: on tick -> FADE (step applies on that same tick).
  FADE: each tick, per channel cur +1 if cur<tgt, -1 if cur>tgt, else unchanged (mode 01: cur=tgt in one tick). No wrap or saturation beyond target. When all three equal target after the step -> HOLD (modes 00/01/10) or DARK (mode 11); hold counter cleared.
  HOLD: modes 00/01 increment hold counter per tick; at HOLD_TICKS, color_idx advances (6->0) -> FADE. Mode 10 stays in HOLD indefinitely. Target change on a tick (sel/mode change) -> FADE, fading from the current cur values, no jump back.
  DARK: stays while mode 11; any other mode on tick -> FADE.
- busy = (cur != target), combinational from registers.
- Commit: in the cycle after pwm_frame_end=1, R/G/B_time_out <= cur values sampled in the pwm_frame_end cycle; upd=1 for that cycle only if any output value changed. If tick and pwm_frame_end coincide, the pre-tick cur is committed.
- en=0: no ticks; commits still occur on pwm_frame_end. Re-asserting en resumes the prescaler from its held count.
- Reset mid-fade: immediate return to reset values; no partial commit.

Test Plan:
1. TICK_DIV=4, HOLD_TICKS=3, mode 00, pwm_frame_end every cycle, release rst -> R rises by 1 every 4 clk, reaching 255 after 255 ticks with G=B=0; HOLD for 3 ticks; color_idx->1; G ramps 0->97 over 97 ticks, busy=0 at (255,97,0).
2. Mode 01 -> outputs jump through the palette once per 4 ticks (1 fade + 3 hold); color_idx sequence 0,1,...,6,0; outputs match palette exactly, including wrap 6->0.
3. pwm_frame_end held 0 for 50 ticks in mode 00 -> outputs stay 0, upd never asserts; single pulse -> next cycle R_time_out=50, upd=1 for exactly one cycle.
4. Mode 10 at (255,0,0) with sel=4 -> R decrements and B increments each tick, reaching (0,0,255) after 255 ticks. sel->2 at tick 100 (155,0,100) -> moves toward (255,255,0) from (155,0,100) with no discontinuity.
5. Mode 11 from (160,32,240) -> all channels reach 0 by tick 240; state DARK, busy=0. en=0 mid-fade freezes outputs. rst=0 mid-fade -> outputs 0 within the same cycle, color_idx=0.
6. tick and pwm_frame_end coincident at cur R=10 -> committed R=10, and R=11 at the next frame end.

Source files
------------

// File: rtl/rgb_fade_sequencer.sv
// Sequences R/G/B duty values through a fixed palette, fading or jumping
// between colours. New duties reach the PWM generator only at period boundaries.
module rgb_fade_sequencer #(
  parameter int TICK_DIV   = 250000,
  parameter int HOLD_TICKS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic [2:0] sel,
  input  logic       pwm_frame_end,
  output logic [7:0] R_time_out,
  output logic [7:0] G_time_out,
  output logic [7:0] B_time_out,
  output logic       upd,
  output logic [2:0] color_idx,
  output logic       busy
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {IDLE, FADE, HOLD, DARK} state_t;
  typedef logic [23:0] rgb_t;

  function automatic rgb_t palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = {8'd255, 8'd0,   8'd0};
      3'd1:    palette = {8'd255, 8'd97,  8'd0};
      3'd2:    palette = {8'd255, 8'd255, 8'd0};
      3'd3:    palette = {8'd0,   8'd255, 8'd0};
      3'd4:    palette = {8'd0,   8'd0,   8'd255};
      3'd5:    palette = {8'd8,   8'd46,  8'd84};
      3'd6:    palette = {8'd160, 8'd32,  8'd240};
      default: palette = {8'd255, 8'd255, 8'd255};
    endcase
  endfunction

  function automatic logic [7:0] step_ch(input logic [7:0] cur, input logic [7:0] tgt,
                                         input logic jump);
    if (jump || cur == tgt) step_ch = tgt;
    else if (cur < tgt)     step_ch = cur + 8'd1;
    else                    step_ch = cur - 8'd1;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] pre_q, pre_d;
  logic [HW-1:0] hold_q, hold_d;
  rgb_t          cur_q, cur_d;
  rgb_t          out_q, out_d;
  logic [2:0]    idx_q, idx_d;
  logic [1:0]    mode_q, mode_d;
  logic          upd_q, upd_d;

  logic          tick;
  logic [2:0]    idx_t;
  rgb_t          tgt_t, stepped, busy_tgt;

  assign tick    = en && (pre_q == CW'(TICK_DIV - 1));
  assign idx_t   = (mode == 2'b10) ? sel : idx_q;
  assign tgt_t   = (mode == 2'b11) ? 24'd0 : palette(idx_t);
  assign stepped = {step_ch(cur_q[23:16], tgt_t[23:16], mode == 2'b01),
                    step_ch(cur_q[15:8],  tgt_t[15:8],  mode == 2'b01),
                    step_ch(cur_q[7:0],   tgt_t[7:0],   mode == 2'b01)};

  always_comb begin
    pre_d = pre_q;
    if (en) pre_d = tick ? '0 : pre_q + CW'(1);
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    if (tick) begin
      mode_d = mode;
      idx_d  = idx_t;
      case (state_q)
        IDLE: begin
          cur_d   = stepped;
          state_d = FADE;
        end
        FADE: begin
          cur_d = stepped;
          if (stepped == tgt_t) begin
            state_d = (mode == 2'b11) ? DARK : HOLD;
            hold_d  = '0;
          end
        end
        HOLD: begin
          // A target change (sel/mode) restarts fading from wherever cur sits.
          if (tgt_t != cur_q) begin
            state_d = FADE;
          end else if (mode == 2'b11) begin
            state_d = DARK;
          end else if (!mode[1]) begin
            if (hold_q + HW'(1) == HW'(HOLD_TICKS)) begin
              hold_d  = '0;
              idx_d   = (idx_q == 3'd6) ? 3'd0 : idx_q + 3'd1;
              state_d = FADE;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
        end
        DARK: begin
          if (mode != 2'b11) state_d = FADE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Commit samples cur before any coincident tick takes effect.
  assign out_d = pwm_frame_end ? cur_q : out_q;
  assign upd_d = pwm_frame_end && (cur_q != out_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      hold_q  <= '0;
      cur_q   <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      mode_q  <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      hold_q  <= hold_d;
      cur_q   <= cur_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      upd_q   <= upd_d;
    end
  end

  assign busy_tgt   = (mode_q == 2'b11) ? 24'd0 : palette(idx_q);
  assign busy       = (cur_q != busy_tgt);
  assign R_time_out = out_q[23:16];
  assign G_time_out = out_q[15:8];
  assign B_time_out = out_q[7:0];
  assign upd        = upd_q;
  assign color_idx  = idx_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer with TICK_DIV=4, HOLD_TICKS=3; commits
// are checked through an expected-value queue filled when pwm_frame_end is pulsed.
module tb_rgb_fade_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] sel = 3'd0;
  logic       pwm_frame_end = 1'b0;
  logic [7:0] R_time_out, G_time_out, B_time_out;
  logic       upd, busy;
  logic [2:0] color_idx;

  rgb_fade_sequencer #(.TICK_DIV(4), .HOLD_TICKS(3)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .pwm_frame_end(pwm_frame_end),
    .R_time_out(R_time_out), .G_time_out(G_time_out), .B_time_out(B_time_out),
    .upd(upd), .color_idx(color_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string    tag;
    int       r, g, b;
    bit       u;
  } exp_t;
  exp_t sb[$];

  int pal_r[8] = '{255, 255, 255, 0,   0,   8,  160, 255};
  int pal_g[8] = '{0,   97,  255, 255, 0,   46, 32,  255};
  int pal_b[8] = '{0,   0,   0,   0,   255, 84, 240, 255};

  int total = 0;
  int bad = 0;
  int n = 0;  // enabled clock edges since reset release; tick k lands on edge 4k

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    bit e;
    e = en && rst;
    @(posedge clk);
    #1;
    if (e) n++;
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  task automatic commit(input string tag, input int er, input int eg, input int eb, input bit eu);
    exp_t e, got;
    e.tag = tag; e.r = er; e.g = eg; e.b = eb; e.u = eu;
    sb.push_back(e);
    pwm_frame_end = 1'b1;
    step();
    pwm_frame_end = 1'b0;
    got = sb.pop_front();
    chk({got.tag, ".R"}, 32'(R_time_out), 32'(got.r));
    chk({got.tag, ".G"}, 32'(G_time_out), 32'(got.g));
    chk({got.tag, ".B"}, 32'(B_time_out), 32'(got.b));
    chk({got.tag, ".upd"}, 32'(upd), 32'(got.u));
    $display("commit %s: R=%0d G=%0d B=%0d upd=%0b", got.tag, R_time_out, G_time_out, B_time_out, upd);
    step();
    chk({got.tag, ".upd_pulse_end"}, 32'(upd), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst.R", 32'(R_time_out), 0);
    chk("rst.G", 32'(G_time_out), 0);
    chk("rst.B", 32'(B_time_out), 0);
    chk("rst.upd", 32'(upd), 0);
    chk("rst.idx", 32'(color_idx), 0);

    // Mode 00 with no frame ends for 50 ticks: outputs must not move
    rst = 1'b1; en = 1'b1; mode = 2'b00;
    while (n < 200) begin
      step();
      chk("noframe.upd", 32'(upd), 0);
    end
    chk("noframe.R", 32'(R_time_out), 0);
    commit("frame50", 50, 0, 0, 1'b1);

    // Frame end coincident with a tick commits the pre-tick value
    run_to(203);
    commit("coinc_pre", 50, 0, 0, 1'b0);
    commit("coinc_post", 51, 0, 0, 1'b1);

    // Ramp to red, hold 3 ticks, then fade G to 97
    run_to(1028);
    chk("red_hold.idx", 32'(color_idx), 0);
    chk("red_hold.busy", 32'(busy), 0);
    run_to(1032);
    chk("adv1.idx", 32'(color_idx), 1);
    chk("adv1.busy", 32'(busy), 1);
    run_to(1419);
    chk("g96.busy", 32'(busy), 1);
    run_to(1420);
    chk("g97.busy", 32'(busy), 0);
    commit("orange", 255, 97, 0, 1'b1);

    // Mode 01: one jump per 4 ticks, idx 2..6 then wrap to 0
    mode = 2'b01;
    for (int j = 0; j < 6; j++) begin
      int k;
      k = (2 + j) % 7;
      run_to(1436 + 16 * j + 1);
      chk($sformatf("jump%0d.idx", k), 32'(color_idx), 32'(k));
      commit($sformatf("jump%0d", k), pal_r[k], pal_g[k], pal_b[k], 1'b1);
    end

    // Mode 10 from red toward blue, redirected to yellow mid-fade
    mode = 2'b10; sel = 3'd4;
    run_to(1525);
    chk("man4.idx", 32'(color_idx), 4);
    commit("man4_k1", 254, 0, 1, 1'b1);
    run_to(1920);
    commit("man4_k100", 155, 0, 100, 1'b1);
    sel = 3'd2;
    run_to(1925);
    commit("man2_m1", 156, 1, 99, 1'b1);
    chk("man2.idx", 32'(color_idx), 2);
    run_to(2520);
    commit("man2_m150", 255, 150, 0, 1'b1);
    run_to(2939);
    chk("man2_m254.busy", 32'(busy), 1);
    run_to(2940);
    chk("man2_done.busy", 32'(busy), 0);
    run_to(2980);
    commit("man2_hold", 255, 255, 0, 1'b1);
    chk("man2_hold.idx", 32'(color_idx), 2);

    // Reach purple: mode 10 sel 6 for one tick, then jump in mode 01
    mode = 2'b10; sel = 3'd6;
    run_to(2985);
    mode = 2'b01;
    run_to(2989);
    commit("purple", 160, 32, 240, 1'b1);

    // Mode 11 fade to black, with an en=0 freeze in the middle
    mode = 2'b11;
    run_to(3392);
    commit("dark_k100", 60, 0, 140, 1'b1);
    en = 1'b0;
    repeat (40) step();
    commit("frozen", 60, 0, 140, 1'b0);
    chk("frozen.busy", 32'(busy), 1);
    en = 1'b1;
    run_to(3952);
    chk("black.busy", 32'(busy), 0);
    chk("black.idx", 32'(color_idx), 6);
    commit("black", 0, 0, 0, 1'b1);

    // Leave DARK in mode 00, then reset mid-fade
    mode = 2'b00;
    run_to(4036);
    commit("refade", 20, 20, 20, 1'b1);
    run_to(4041);
    rst = 1'b0;
    #1;
    chk("midrst.R", 32'(R_time_out), 0);
    chk("midrst.G", 32'(G_time_out), 0);
    chk("midrst.B", 32'(B_time_out), 0);
    chk("midrst.upd", 32'(upd), 0);
    chk("midrst.idx", 32'(color_idx), 0);
    en = 1'b0;
    step();
    rst = 1'b1;
    commit("post_rst", 0, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
